// File: rtl/pll_reset_sequencer_if.sv
// PLL control/status bundle between the reset sequencer (master) and the PLL/domain side (slave).
// SXR_PLL_SEQ_STATUS_EN adds the seq_state/relock_cnt status signals.
interface pll_reset_sequencer_if;
    logic       pll_locked;
    logic       pll_rst;
    logic [2:0] dom_rst;
    logic       sys_ready;
    logic       fault;
`ifdef SXR_PLL_SEQ_STATUS_EN
    logic [2:0] seq_state;
    logic [7:0] relock_cnt;
`endif

    modport master (
        input  pll_locked,
`ifdef SXR_PLL_SEQ_STATUS_EN
        output seq_state,
        output relock_cnt,
`endif
        output pll_rst,
        output dom_rst,
        output sys_ready,
        output fault
    );

    modport slave (
        output pll_locked,
`ifdef SXR_PLL_SEQ_STATUS_EN
        input  seq_state,
        input  relock_cnt,
`endif
        input  pll_rst,
        input  dom_rst,
        input  sys_ready,
        input  fault
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: drives pll_rst, filters locked, releases domain resets 0,1,2 staggered,
// retries on timeout/filter abort and latches fault. Optional status ports: SXR_PLL_SEQ_STATUS_EN.
module pll_reset_sequencer #(
    parameter int unsigned RST_HOLD_CYCLES     = 16,
    parameter int unsigned LOCK_FILTER_CYCLES  = 64,
    parameter int unsigned STAGGER_CYCLES      = 8,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65535,
    parameter int unsigned MAX_RETRY           = 3,
    parameter int unsigned CNT_W               = 16
) (
    input  logic                   refclk,
    input  logic                   rst,
    pll_reset_sequencer_if.master  bus
);

    localparam int unsigned RETRY_W = $clog2(MAX_RETRY + 1);

    localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]   FILTER_LAST  = CNT_W'(LOCK_FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STAGGER_MID  = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STAGGER_END  = CNT_W'(2 * STAGGER_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_FILTER    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4,
        S_FAULT     = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [1:0]         sync_q, sync_d;
    logic [2:0]         dom_rst_q, dom_rst_d;
    logic               pll_rst_q, pll_rst_d;
    logic               sys_ready_q, sys_ready_d;
    logic               fault_q, fault_d;
    logic               locked_s;
    logic               lost_lock;
    logic               fail_attempt;
`ifdef SXR_PLL_SEQ_STATUS_EN
    logic [7:0]         relock_q, relock_d;
`endif

    assign locked_s = sync_q[1];

    always_comb begin
        sync_d       = {sync_q[0], bus.pll_locked};
        state_d      = state_q;
        retry_d      = retry_q;
        dom_rst_d    = dom_rst_q;
        fail_attempt = 1'b0;
        // Loss of lock after release resequences without charging a retry.
        lost_lock    = !locked_s && (state_q == S_RELEASE || state_q == S_RUN);

        case (state_q)
            S_RESET: begin
                if (cnt_q == HOLD_LAST) state_d = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                if (locked_s)                  state_d = S_FILTER;
                else if (cnt_q == TIMEOUT_LAST) fail_attempt = 1'b1;
            end
            S_FILTER: begin
                if (!locked_s) begin
                    fail_attempt = 1'b1;
                end else if (cnt_q == FILTER_LAST) begin
                    state_d   = S_RELEASE;
                    dom_rst_d = 3'b110;
                end
            end
            S_RELEASE: begin
                if (lost_lock) begin
                    state_d = S_RESET;
                end else if (cnt_q == STAGGER_MID) begin
                    dom_rst_d = 3'b100;
                end else if (cnt_q == STAGGER_END) begin
                    state_d   = S_RUN;
                    dom_rst_d = 3'b000;
                    retry_d   = '0;
                end
            end
            S_RUN: begin
                if (lost_lock) state_d = S_RESET;
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase

        if (fail_attempt) begin
            retry_d = retry_q + 1'b1;
            state_d = (retry_d == RETRY_LIMIT) ? S_FAULT : S_RESET;
        end

        if (state_d == S_RESET || state_d == S_WAIT_LOCK ||
            state_d == S_FILTER || state_d == S_FAULT) begin
            dom_rst_d = 3'b111;
        end

        // RUN and FAULT have no timed exits, so the counter parks there.
        if (state_d != state_q)                         cnt_d = '0;
        else if (state_q == S_RUN || state_q == S_FAULT) cnt_d = cnt_q;
        else                                            cnt_d = cnt_q + 1'b1;

        pll_rst_d   = (state_d == S_RESET) || (state_d == S_FAULT);
        sys_ready_d = (state_d == S_RUN);
        fault_d     = (state_d == S_FAULT);

`ifdef SXR_PLL_SEQ_STATUS_EN
        relock_d = relock_q;
        if (lost_lock && relock_q != 8'hFF) relock_d = relock_q + 1'b1;
`endif
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q     <= S_RESET;
            cnt_q       <= '0;
            retry_q     <= '0;
            sync_q      <= '0;
            dom_rst_q   <= 3'b111;
            pll_rst_q   <= 1'b1;
            sys_ready_q <= 1'b0;
            fault_q     <= 1'b0;
`ifdef SXR_PLL_SEQ_STATUS_EN
            relock_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            sync_q      <= sync_d;
            dom_rst_q   <= dom_rst_d;
            pll_rst_q   <= pll_rst_d;
            sys_ready_q <= sys_ready_d;
            fault_q     <= fault_d;
`ifdef SXR_PLL_SEQ_STATUS_EN
            relock_q    <= relock_d;
`endif
        end
    end

    assign bus.pll_rst   = pll_rst_q;
    assign bus.dom_rst   = dom_rst_q;
    assign bus.sys_ready = sys_ready_q;
    assign bus.fault     = fault_q;
`ifdef SXR_PLL_SEQ_STATUS_EN
    assign bus.seq_state  = state_q;
    assign bus.relock_cnt = relock_q;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with small parameters (hold 4, filter 8, stagger 2,
// timeout 32, retries 2); expected cycle positions are hand-derived from the reset/lock edges.
module tb_pll_reset_sequencer;

    logic refclk;
    logic rst;
    int   n_checks;
    int   n_errors;

    pll_reset_sequencer_if bus_if ();

    pll_reset_sequencer #(
        .RST_HOLD_CYCLES     (4),
        .LOCK_FILTER_CYCLES  (8),
        .STAGGER_CYCLES      (2),
        .LOCK_TIMEOUT_CYCLES (32),
        .MAX_RETRY           (2),
        .CNT_W               (16)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .bus    (bus_if)
    );

    initial refclk = 1'b0;
    always #10 refclk = ~refclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    // One-cycle drop of pll_locked; returns just after the edge where the domains re-assert.
    task automatic lock_drop();
        bus_if.pll_locked = 1'b0;
        tick(1);
        bus_if.pll_locked = 1'b1;
        tick(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus_if.pll_locked = 1'b0;

        // Nominal lock
        tick(1);
        rst = 1'b0;
        chk("rst_pll_rst",   32'(bus_if.pll_rst),   1);
        chk("rst_dom_rst",   32'(bus_if.dom_rst),   7);
        chk("rst_sys_ready", 32'(bus_if.sys_ready), 0);
        chk("rst_fault",     32'(bus_if.fault),     0);
        tick(3);
        chk("hold_pll_rst",  32'(bus_if.pll_rst),   1);
        tick(1);
        chk("hold_end",      32'(bus_if.pll_rst),   0);
        chk("wait_dom_rst",  32'(bus_if.dom_rst),   7);
        tick(9);
        bus_if.pll_locked = 1'b1;
        tick(10);
        chk("filter_dom",    32'(bus_if.dom_rst),   7);
        tick(1);
        chk("rel_dom0",      32'(bus_if.dom_rst),   6);
        tick(1);
        chk("rel_stagger",   32'(bus_if.dom_rst),   6);
        tick(1);
        chk("rel_dom1",      32'(bus_if.dom_rst),   4);
        chk("rel_not_ready", 32'(bus_if.sys_ready), 0);
        tick(1);
        chk("rel_hold2",     32'(bus_if.dom_rst),   4);
        tick(1);
        chk("run_dom",       32'(bus_if.dom_rst),   0);
        chk("run_ready",     32'(bus_if.sys_ready), 1);
        chk("run_pll_rst",   32'(bus_if.pll_rst),   0);

        // Loss of lock in RUN, repeated
        for (int i = 0; i < 5; i++) begin
            tick(2);
            bus_if.pll_locked = 1'b0;
            tick(1);
            bus_if.pll_locked = 1'b1;
            tick(1);
            chk("lol_pre_dom",   32'(bus_if.dom_rst),   0);
            tick(1);
            chk("lol_dom",       32'(bus_if.dom_rst),   7);
            chk("lol_ready",     32'(bus_if.sys_ready), 0);
            chk("lol_pll_rst",   32'(bus_if.pll_rst),   1);
            tick(16);
            chk("lol_rel_dom",   32'(bus_if.dom_rst),   4);
            tick(1);
            chk("lol_run_dom",   32'(bus_if.dom_rst),   0);
            chk("lol_run_ready", 32'(bus_if.sys_ready), 1);
            chk("lol_fault",     32'(bus_if.fault),     0);
        end

        // Reset mid-release
        tick(2);
        lock_drop();
        tick(13);
        chk("mid_rel_dom",   32'(bus_if.dom_rst),   6);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_rst_dom",   32'(bus_if.dom_rst),   7);
        chk("mid_rst_pll",   32'(bus_if.pll_rst),   1);
        chk("mid_rst_ready", 32'(bus_if.sys_ready), 0);
        tick(1);
        chk("mid_no_partial", 32'(bus_if.dom_rst),  7);
        tick(3);
        chk("mid_wait_pll",  32'(bus_if.pll_rst),   0);
        tick(13);
        chk("mid_run_ready", 32'(bus_if.sys_ready), 1);
        chk("mid_run_dom",   32'(bus_if.dom_rst),   0);

        // Filter abort then successful retry
        bus_if.pll_locked = 1'b0;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(5);
        bus_if.pll_locked = 1'b1;
        tick(5);
        bus_if.pll_locked = 1'b0;
        tick(1);
        bus_if.pll_locked = 1'b1;
        tick(1);
        chk("abort_pre_pll", 32'(bus_if.pll_rst),   0);
        tick(1);
        chk("abort_pll_rst", 32'(bus_if.pll_rst),   1);
        chk("abort_dom",     32'(bus_if.dom_rst),   7);
        chk("abort_fault",   32'(bus_if.fault),     0);
        tick(3);
        chk("abort_hold",    32'(bus_if.pll_rst),   1);
        tick(1);
        chk("abort_wait",    32'(bus_if.pll_rst),   0);
        tick(8);
        chk("retry_filter",  32'(bus_if.dom_rst),   7);
        tick(1);
        chk("retry_rel",     32'(bus_if.dom_rst),   6);
        tick(4);
        chk("retry_run",     32'(bus_if.sys_ready), 1);

        // Timeouts to fault; only reachable after two fresh attempts if RUN cleared retry
        tick(2);
        bus_if.pll_locked = 1'b0;
        tick(3);
        chk("to_lol_dom",    32'(bus_if.dom_rst),   7);
        chk("to_lol_ready",  32'(bus_if.sys_ready), 0);
        tick(4);
        chk("to_wait1",      32'(bus_if.pll_rst),   0);
        tick(31);
        chk("to_win1_end",   32'(bus_if.pll_rst),   0);
        tick(1);
        chk("to_retry1_pll", 32'(bus_if.pll_rst),   1);
        chk("to_retry1_flt", 32'(bus_if.fault),     0);
        tick(4);
        chk("to_wait2",      32'(bus_if.pll_rst),   0);
        tick(31);
        chk("to_win2_flt",   32'(bus_if.fault),     0);
        tick(1);
        chk("fault_set",     32'(bus_if.fault),     1);
        chk("fault_pll_rst", 32'(bus_if.pll_rst),   1);
        chk("fault_dom",     32'(bus_if.dom_rst),   7);
        chk("fault_ready",   32'(bus_if.sys_ready), 0);
        bus_if.pll_locked = 1'b1;
        tick(40);
        chk("fault_sticky",  32'(bus_if.fault),     1);
        chk("fault_dom_hold", 32'(bus_if.dom_rst),  7);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("fault_clear",   32'(bus_if.fault),     0);
        chk("fault_clr_pll", 32'(bus_if.pll_rst),   1);

`ifdef SXR_PLL_SEQ_STATUS_EN
        // Status: state tracking and relock saturation
        chk("st_reset",      32'(bus_if.seq_state),  0);
        chk("st_relock0",    32'(bus_if.relock_cnt), 0);
        tick(4);
        chk("st_wait",       32'(bus_if.seq_state),  1);
        tick(1);
        chk("st_filter",     32'(bus_if.seq_state),  2);
        tick(8);
        chk("st_release",    32'(bus_if.seq_state),  3);
        tick(4);
        chk("st_run",        32'(bus_if.seq_state),  4);
        for (int i = 0; i < 300; i++) begin
            tick(2);
            lock_drop();
            if (i == 0) begin
                chk("st_lol_state", 32'(bus_if.seq_state),  0);
                chk("st_relock1",   32'(bus_if.relock_cnt), 1);
            end
            if (i == 254) chk("st_relock255", 32'(bus_if.relock_cnt), 255);
            tick(17);
        end
        chk("st_relock_sat", 32'(bus_if.relock_cnt), 255);
        chk("st_run_final",  32'(bus_if.seq_state),  4);
        chk("st_fault_zero", 32'(bus_if.fault),      0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
